// File: rtl/shuffle_hs_pkg.sv
// Shared constants for the shuffle-stage nonce handshake: receiver and sender
// FSM encodings plus the default nonce width.
package shuffle_hs_pkg;

   localparam int NONCE_WIDTH_DEF = 7;

   // Two-bit encodings leave room for illegal values that must recover to idle
   typedef enum logic [1:0] {
      HS_IDLE = 2'd0,
      HS_ACK  = 2'd1
   } hs_state_e;

   typedef enum logic [1:0] {
      SND_IDLE     = 2'd0,
      SND_REQ      = 2'd1,
      SND_WAIT_REL = 2'd2
   } snd_state_e;

   function automatic logic is_legal_hs(input logic [1:0] enc);
      return (enc == 2'd0) || (enc == 2'd1);
   endfunction

endpackage

// File: rtl/shuffle_loader_nonce_fifo.sv
// Small show-ahead FIFO holding acknowledged nonces until the implode side
// pops them; occupancy is an exact registered counter.
module nonce_fifo
   import shuffle_hs_pkg::*;
#(
   parameter int nonce_width = NONCE_WIDTH_DEF,
   parameter int FIFO_DEPTH  = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int CNT_W      = PTR_W + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [nonce_width-1:0] push_data,
   input  logic                   pop,
   output logic [nonce_width-1:0] head,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   empty
);

   logic [nonce_width-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r;
   logic [PTR_W-1:0]       rd_ptr_r;
   logic [CNT_W-1:0]       count_r;
   logic                   do_pop_s;

   assign empty    = (count_r == {CNT_W{1'b0}});
   assign full     = (count_r == CNT_W'(FIFO_DEPTH));
   assign do_pop_s = pop & ~empty;
   assign head     = mem_r[rd_ptr_r];
   assign count    = count_r;

   // Storage, wrapping pointers and occupancy counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {nonce_width{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/shuffle_loader.sv
// Receiver side of the 4-phase nonce handshake: samples the request once,
// pushes one nonce per request and withholds ack while the FIFO is full.
module shuffle_loader
   import shuffle_hs_pkg::*;
#(
   parameter int nonce_width = NONCE_WIDTH_DEF,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_handshake,
   input  logic [nonce_width-1:0] i_data,
   output logic                   o_handshake_recv,
   output logic                   o_valid,
   output logic [nonce_width-1:0] o_data,
   input  logic                   i_ready,
   output logic [CNT_W-1:0]       o_count,
   output logic                   o_full
);

   logic      hs_q_r;
   hs_state_e state_r;
   logic      ack_r;
   logic      push_s;
   logic      full_s;
   logic      empty_s;

   // Request sampler; the FSM never looks at the raw input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q_r <= 1'b0;
      end else begin
         hs_q_r <= i_handshake;
      end
   end

   // Push only from IDLE, so a long-held request yields a single entry
   always_comb begin
      push_s = 1'b0;
      if ((state_r == HS_IDLE) && hs_q_r && !full_s) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
   end

   // Handshake FSM with registered acknowledge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= HS_IDLE;
         ack_r   <= 1'b0;
      end else begin
         case (state_r)
            HS_IDLE: begin
               if (push_s) begin
                  ack_r   <= 1'b1;
                  state_r <= HS_ACK;
               end else begin
                  ack_r   <= 1'b0;
               end
            end
            HS_ACK: begin
               if (!hs_q_r) begin
                  ack_r   <= 1'b0;
                  state_r <= HS_IDLE;
               end else begin
                  ack_r   <= 1'b1;
               end
            end
            default: begin
               ack_r   <= 1'b0;
               state_r <= HS_IDLE;
            end
         endcase
      end
   end

   nonce_fifo #(
      .nonce_width (nonce_width),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (i_data),
      .pop       (i_ready),
      .head      (o_data),
      .count     (o_count),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign o_handshake_recv = ack_r;
   assign o_valid          = ~empty_s;
   assign o_full           = full_s;

endmodule

// File: tb/tb_shuffle_loader.sv
// Directed bench for shuffle_loader: stimulus queues expected nonces, a
// negedge monitor checks every pop against that queue.
module tb_shuffle_loader;

   logic       clk;
   logic       rst_n;
   logic       i_handshake;
   logic [6:0] i_data;
   logic       o_handshake_recv;
   logic       o_valid;
   logic [6:0] o_data;
   logic       i_ready;
   logic [2:0] o_count;
   logic       o_full;

   int         total = 0;
   int         bad = 0;
   int         max_count = 0;
   bit         rand_ready = 1'b0;
   logic [6:0] exp_q[$];

   shuffle_loader dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_handshake      (i_handshake),
      .i_data           (i_data),
      .o_handshake_recv (o_handshake_recv),
      .o_valid          (o_valid),
      .o_data           (o_data),
      .i_ready          (i_ready),
      .o_count          (o_count),
      .o_full           (o_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for ack to reach lvl; cyc = cycles taken, or -1 on timeout
   task automatic wait_ack(input logic lvl, input int max, output int cyc);
      bit done;
      done = 1'b0;
      cyc  = -1;
      for (int i = 1; i <= max; i++) begin
         if (!done) begin
            tick();
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
            if (o_handshake_recv == lvl) begin
               cyc  = i;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic xfer(input logic [6:0] d);
      int c;
      i_data      = d;
      i_handshake = 1'b1;
      exp_q.push_back(d);
      wait_ack(1'b1, 200, c);
      check("xfer_ack_rise", (c > 0) ? 1 : 0, 1);
      i_handshake = 1'b0;
      wait_ack(1'b0, 200, c);
      check("xfer_ack_fall", (c > 0) ? 1 : 0, 1);
   endtask

   task automatic drain();
      i_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (o_count != 3'd0) tick();
      end
      i_ready = 1'b0;
      check("drain_count", int'(o_count), 0);
   endtask

   // Scoreboard monitor: a pop happens at the next posedge when valid && ready
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_order: got 0x%0h want nothing (queue empty)", o_data);
         end else begin
            check("pop_order", int'(o_data), int'(exp_q.pop_front()));
         end
      end
      if (int'(o_count) > max_count) max_count = int'(o_count);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c;
      rst_n       = 1'b0;
      i_handshake = 1'b0;
      i_data      = 7'h00;
      i_ready     = 1'b0;
      tick();
      tick();
      check("rst_ack", int'(o_handshake_recv), 0);
      check("rst_valid", int'(o_valid), 0);
      check("rst_count", int'(o_count), 0);
      check("rst_full", int'(o_full), 0);
      check("rst_data", int'(o_data), 0);
      rst_n = 1'b1;
      tick();

      // Single transfer: ack two edges after the request
      i_data      = 7'h2A;
      i_handshake = 1'b1;
      exp_q.push_back(7'h2A);
      tick();
      check("single_ack_n1", int'(o_handshake_recv), 0);
      tick();
      check("single_ack_n2", int'(o_handshake_recv), 1);
      check("single_valid", int'(o_valid), 1);
      check("single_data", int'(o_data), 'h2A);
      check("single_count", int'(o_count), 1);
      i_handshake = 1'b0;
      tick();
      check("single_rel_m1", int'(o_handshake_recv), 1);
      tick();
      check("single_rel_m2", int'(o_handshake_recv), 0);
      drain();

      // Held request: one push only
      i_data      = 7'h11;
      i_handshake = 1'b1;
      exp_q.push_back(7'h11);
      for (int i = 0; i < 20; i++) tick();
      check("held_count", int'(o_count), 1);
      check("held_ack", int'(o_handshake_recv), 1);
      i_handshake = 1'b0;
      wait_ack(1'b0, 5, c);
      check("held_rel", c, 2);
      drain();

      // Back-pressure
      for (int d = 1; d <= 4; d++) xfer(7'(d));
      check("bp_full", int'(o_full), 1);
      check("bp_count", int'(o_count), 4);
      i_data      = 7'd5;
      i_handshake = 1'b1;
      exp_q.push_back(7'd5);
      for (int i = 0; i < 5; i++) tick();
      check("bp_stall_ack", int'(o_handshake_recv), 0);
      check("bp_stall_count", int'(o_count), 4);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("bp_head_after_pop", int'(o_data), 2);
      check("bp_count_after_pop", int'(o_count), 3);
      wait_ack(1'b1, 3, c);
      check("bp_unblock_in_3", (c >= 1) ? 1 : 0, 1);
      check("bp_refill_count", int'(o_count), 4);
      i_handshake = 1'b0;
      wait_ack(1'b0, 5, c);
      drain();

      // Simultaneous push and pop at count 2
      xfer(7'd1);
      xfer(7'd2);
      check("pp_pre_count", int'(o_count), 2);
      i_data      = 7'd3;
      i_handshake = 1'b1;
      exp_q.push_back(7'd3);
      tick();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("pp_ack", int'(o_handshake_recv), 1);
      check("pp_count", int'(o_count), 2);
      check("pp_head", int'(o_data), 2);
      i_handshake = 1'b0;
      wait_ack(1'b0, 5, c);
      drain();

      // Wrap-around with random consumer
      max_count  = 0;
      rand_ready = 1'b1;
      for (int d = 0; d < 64; d++) xfer(7'(d));
      rand_ready = 1'b0;
      drain();
      check("wrap_queue_empty", exp_q.size(), 0);
      check("wrap_count_bound", (max_count <= 4) ? 1 : 0, 1);

      // Asynchronous reset while in ACK with three entries
      xfer(7'h21);
      xfer(7'h22);
      i_data      = 7'h23;
      i_handshake = 1'b1;
      exp_q.push_back(7'h23);
      wait_ack(1'b1, 10, c);
      check("mid_count_pre", int'(o_count), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack", int'(o_handshake_recv), 0);
      check("mid_rst_valid", int'(o_valid), 0);
      check("mid_rst_count", int'(o_count), 0);
      check("mid_rst_full", int'(o_full), 0);
      exp_q.delete();
      i_handshake = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      xfer(7'h55);
      check("post_rst_valid", int'(o_valid), 1);
      check("post_rst_data", int'(o_data), 'h55);
      drain();
      check("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shuffle_loader.md
Name: shuffle_loader

Overview:
- Receiving end of the 4-phase req/ack nonce handshake driven by the shuffle stage's unloader.
- Samples the request, captures the nonce, acknowledges it, and queues nonces in a small show-ahead FIFO.
- Implode-side logic pops nonces from the FIFO with a valid/ready interface.
- Withholds acknowledge while the FIFO is full, which back-pressures the shuffle side.

Parameters:
- nonce_width, 7, width of nonce/slot index carried on the handshake.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- i_handshake  in  1  request from sender; registered at the sender, held high until ack seen.
- i_data  in  nonce_width  nonce from sender; stable while i_handshake is high.
- o_handshake_recv  out  1  acknowledge to sender (level, registered).
- o_valid  out  1  FIFO head is valid.
- o_data  out  nonce_width  FIFO head (show-ahead).
- i_ready  in  1  consumer pops the head when o_valid && i_ready.
- o_count  out  CNT_W  current FIFO occupancy.
- o_full  out  1  occupancy == FIFO_DEPTH.

Behaviour:
- Reset: applied asynchronously while rst_n=0. o_handshake_recv=0, o_valid=0, o_count=0, o_full=0, o_data=0, FSM=IDLE, hs_q=0, pointers=0.
- Reset mid-handshake drops ack immediately and discards all FIFO contents. The sender recovers through its own reset.
- hs_q is i_handshake registered once; the FSM uses only hs_q.
- IDLE:
  - If hs_q=1 and !o_full: push i_data, set ack<=1, go to ACK.
  - If hs_q=1 and o_full: stay in IDLE with ack=0 (stall).
- ACK:
  - Hold ack=1 until hs_q=0, then ack<=0 and go to IDLE.
  - i_data is not sampled again in this state.
- Exactly one push per request rising phase. A request held high for many cycles is never pushed twice.
- Latency: i_handshake rises after edge N → hs_q=1 after N+1 → push and ack=1 after N+2. If the FIFO was empty, o_valid=1 and o_data=nonce after N+2.
- Release latency: i_handshake falls after edge M → ack=0 after edge M+2.
- FIFO:
  - Show-ahead; o_data always reflects the head entry.
  - Pop when o_valid && i_ready. Pop while empty is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, a pop in the same cycle as the FSM's full check does not unblock that cycle. The FSM sees the new count next cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - o_count is exact; o_full and o_valid are derived from the registered count.
- No overflow is possible by construction; a push is never issued when o_full=1. Verification asserts this.
- Unknown or illegal FSM encoding recovers to IDLE with ack=0.

Decomposition:
- Package shuffle_hs_pkg holds the FSM state localparams (HS_IDLE=0, HS_ACK=1) and the default nonce_width.
- The sender-side state constants move into the same package.
- One sub-module: nonce_fifo (parameters nonce_width, FIFO_DEPTH; ports push, push_data, pop, head, count, full, empty).
- shuffle_loader contains the sampler register, the FSM, and the nonce_fifo instance.

Test Plan:
- Single transfer:
  - Stimulus: sender model raises i_handshake with i_data=7'h2A, i_ready=0.
  - Response: ack rises 2 cycles later; o_valid=1, o_data=2A, o_count=1.
  - Dropping the request → ack falls 2 cycles later.
- Held request:
  - Stimulus: i_handshake held high 20 cycles with data=7'h11.
  - Response: exactly one push (o_count=1); ack stays high until the request drops.
- Back-pressure with FIFO_DEPTH=4, i_ready=0:
  - Stimulus: five transfers with data 1,2,3,4,5.
  - Response: four acked, o_full=1, fifth request sees ack=0.
  - Then assert i_ready for one pop → head becomes 2, and the fifth transfer is acked within 3 cycles.
- Simultaneous push/pop:
  - Stimulus: o_count=2, i_ready=1 on the push cycle.
  - Response: o_count stays 2; pop order 1,2,3 preserved.
- Wrap-around:
  - Stimulus: 64 transfers of incrementing data with a random i_ready pattern.
  - Response: consumer receives 0..63 in order, no loss or duplication, o_count never exceeds 4.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while in ACK with o_count=3.
  - Response: ack, o_valid, o_count and o_full go to 0 without waiting for a clock edge.
  - After release, the next transfer with data 7'h55 is received normally.
